// File: rtl/rv_dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package rv_dmem_pkg;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wr_data;
      logic [3:0]  byte_en;
      logic        wr_en;
      logic        rd_en;
   } t_core2mem_req;

   typedef enum logic [1:0] {
      DMEM_REG_RAM,
      DMEM_REG_MMIO,
      DMEM_REG_NONE
   } t_dmem_region;

   localparam logic [3:0] MMIO_CYCLE_LO = 4'h0;
   localparam logic [3:0] MMIO_CYCLE_HI = 4'h4;
   localparam logic [3:0] MMIO_TOHOST   = 4'h8;
   localparam logic [3:0] MMIO_SCRATCH  = 4'hC;

   function automatic logic [31:0] be_merge(
      input logic [31:0] old_w,
      input logic [31:0] new_w,
      input logic [3:0]  be
   );
      logic [31:0] r;
      r = old_w;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/rv_dmem_mmio.sv
// MMIO bank: cycle counter, scratch, tohost mailbox and read mux.
// Exists only when DMEM_MMIO_EN is defined.
`ifdef DMEM_MMIO_EN
module rv_dmem_mmio
   import rv_dmem_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        we_i,
   input  logic [3:0]  off_i,
   input  logic [3:0]  be_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        tohost_valid_o,
   output logic [31:0] tohost_data_o
);

   logic [63:0] cyc_q, cyc_d;
   logic [31:0] scratch_q, scratch_d;
   logic [31:0] tohost_q, tohost_d;
   logic        thv_q, thv_d;

   always_comb begin
      cyc_d     = cyc_q + 64'd1;
      scratch_d = scratch_q;
      tohost_d  = tohost_q;
      thv_d     = thv_q;
      if (we_i) begin
         unique case (off_i)
            MMIO_TOHOST: begin
               tohost_d = be_merge(tohost_q, wdata_i, be_i);
               thv_d    = 1'b1;
            end
            MMIO_SCRATCH: scratch_d = be_merge(scratch_q, wdata_i, be_i);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cyc_q     <= '0;
         scratch_q <= '0;
         tohost_q  <= '0;
         thv_q     <= 1'b0;
      end else begin
         cyc_q     <= cyc_d;
         scratch_q <= scratch_d;
         tohost_q  <= tohost_d;
         thv_q     <= thv_d;
      end
   end

   always_comb begin
      rdata_o = '0;
      unique case (off_i)
         MMIO_CYCLE_LO: rdata_o = cyc_q[31:0];
         MMIO_CYCLE_HI: rdata_o = cyc_q[63:32];
         MMIO_SCRATCH:  rdata_o = scratch_q;
         default:       rdata_o = '0;
      endcase
   end

   assign tohost_valid_o = thv_q;
   assign tohost_data_o  = tohost_q;

endmodule
`endif

// File: rtl/rv_dmem.sv
// Data-memory responder: region decode, RAM with byte lanes, fault capture.
// MMIO bank present only when DMEM_MMIO_EN is defined.
module rv_dmem
   import rv_dmem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 1024,
   parameter logic [31:0] DMEM_BASE   = 32'h0001_0000,
   parameter logic [31:0] MMIO_BASE   = 32'h0002_0000
) (
   input  logic          clk,
   input  logic          rst,
   input  t_core2mem_req core2dmem_req,
   output logic [31:0]   dmem_rd_data,
   output logic          tohost_valid,
   output logic [31:0]   tohost_data,
   output logic          fault,
   output logic [31:0]   fault_addr
);

   localparam int          IW       = $clog2(DEPTH_WORDS);
   localparam logic [31:0] RAM_MASK = 32'(4 * DEPTH_WORDS) - 32'd1;

   t_dmem_region region;
   logic [31:0]  addr;
   logic [IW-1:0] idx;
   logic         rd, wr, both, bad;
   logic [31:0]  mmio_rdata;
   logic [31:0]  mem_q [DEPTH_WORDS];
   logic         fault_q, fault_d;
   logic [31:0]  fault_addr_q, fault_addr_d;

   assign addr = core2dmem_req.addr;
   assign idx  = addr[IW+1:2];
   assign both = core2dmem_req.rd_en & core2dmem_req.wr_en;
   assign rd   = core2dmem_req.rd_en & ~both;
   assign wr   = core2dmem_req.wr_en & ~both;

   always_comb begin
      region = DMEM_REG_NONE;
      if ((addr & ~RAM_MASK) == DMEM_BASE) region = DMEM_REG_RAM;
`ifdef DMEM_MMIO_EN
      else if (addr[31:4] == MMIO_BASE[31:4]) region = DMEM_REG_MMIO;
`endif
   end

   assign bad = both |
      ((core2dmem_req.rd_en | core2dmem_req.wr_en) &
       (region == DMEM_REG_NONE));

   // RAM is intentionally not reset; reset only blocks the write.
   always_ff @(posedge clk) begin
      if (rst && wr && region == DMEM_REG_RAM) begin
         mem_q[idx] <= be_merge(mem_q[idx], core2dmem_req.wr_data,
                                core2dmem_req.byte_en);
      end
   end

`ifdef DMEM_MMIO_EN
   rv_dmem_mmio u_mmio (
      .clk_i          (clk),
      .rst_ni         (rst),
      .we_i           (wr && region == DMEM_REG_MMIO),
      .off_i          ({addr[3:2], 2'b00}),
      .be_i           (core2dmem_req.byte_en),
      .wdata_i        (core2dmem_req.wr_data),
      .rdata_o        (mmio_rdata),
      .tohost_valid_o (tohost_valid),
      .tohost_data_o  (tohost_data)
   );
`else
   assign mmio_rdata   = '0;
   assign tohost_valid = 1'b0;
   assign tohost_data  = '0;
`endif

   always_comb begin
      dmem_rd_data = '0;
      if (rd) begin
         unique case (region)
            DMEM_REG_RAM:  dmem_rd_data = mem_q[idx];
            DMEM_REG_MMIO: dmem_rd_data = mmio_rdata;
            default:       dmem_rd_data = '0;
         endcase
      end
   end

   always_comb begin
      fault_d      = fault_q;
      fault_addr_d = fault_addr_q;
      if (bad && !fault_q) begin
         fault_d      = 1'b1;
         fault_addr_d = addr;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         fault_q      <= 1'b0;
         fault_addr_q <= '0;
      end else begin
         fault_q      <= fault_d;
         fault_addr_q <= fault_addr_d;
      end
   end

   assign fault      = fault_q;
   assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_rv_dmem.sv
// Directed self-checking bench for rv_dmem.
// MMIO checks adapt to whether DMEM_MMIO_EN is defined.
module tb_rv_dmem;
   import rv_dmem_pkg::*;

   logic          clk;
   logic          rst;
   t_core2mem_req req;
   logic [31:0]   rd_data;
   logic          tohost_valid;
   logic [31:0]   tohost_data;
   logic          fault;
   logic [31:0]   fault_addr;

   int checks = 0;
   int errors = 0;

   rv_dmem dut (
      .clk           (clk),
      .rst           (rst),
      .core2dmem_req (req),
      .dmem_rd_data  (rd_data),
      .tohost_valid  (tohost_valid),
      .tohost_data   (tohost_data),
      .fault         (fault),
      .fault_addr    (fault_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic put(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input logic w, input logic r);
      @(negedge clk);
      req.addr    = a;
      req.wr_data = d;
      req.byte_en = be;
      req.wr_en   = w;
      req.rd_en   = r;
      #1;
   endtask

   logic [31:0] ca, cb;

   initial begin
      rst = 1'b0;
      req = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_fault", {31'b0, fault}, 32'd0);
      chk("rst_faddr", fault_addr, 32'd0);
      chk("rst_thv", {31'b0, tohost_valid}, 32'd0);
      chk("rst_thd", tohost_data, 32'd0);
      chk("rst_rd_idle", rd_data, 32'd0);
      rst = 1'b1;

      put(32'h0001_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0);
      put(32'h0001_0010, 32'h0, 4'h0, 1'b0, 1'b1);
      chk("word_rd", rd_data, 32'hDEAD_BEEF);
      chk("word_fault", {31'b0, fault}, 32'd0);

      put(32'h0001_0010, 32'h00AA_0000, 4'b0100, 1'b1, 1'b0);
      put(32'h0001_0010, 32'h0, 4'h0, 1'b0, 1'b1);
      chk("lane_rd", rd_data, 32'hDEAA_BEEF);

      put(32'h0001_0010, 32'h0, 4'h0, 1'b0, 1'b0);
      chk("idle_rd_zero", rd_data, 32'd0);

      put(32'h0001_0010, 32'hFFFF_FFFF, 4'h0, 1'b1, 1'b0);
      put(32'h0001_0010, 32'h0, 4'h0, 1'b0, 1'b1);
      chk("be0_noop", rd_data, 32'hDEAA_BEEF);

      put(32'h0001_0FFC, 32'h1122_3344, 4'hF, 1'b1, 1'b0);
      put(32'h0001_0FFF, 32'h0, 4'h0, 1'b0, 1'b1);
      chk("top_word", rd_data, 32'h1122_3344);

      put(32'h0001_0000, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b0);

`ifdef DMEM_MMIO_EN
      put(32'h0002_0008, 32'h0000_0001, 4'hF, 1'b1, 1'b0);
      put(32'h0002_0008, 32'h0, 4'h0, 1'b0, 1'b1);
      chk("tohost_rd0", rd_data, 32'd0);
      chk("tohost_valid", {31'b0, tohost_valid}, 32'd1);
      chk("tohost_data", tohost_data, 32'd1);
      put(32'h0002_0008, 32'h0000_AB00, 4'b0010, 1'b1, 1'b0);
      put(32'h0002_0000, 32'h0, 4'h0, 1'b0, 1'b0);
      chk("tohost_lane", tohost_data, 32'h0000_AB01);
      put(32'h0002_000C, 32'h1234_5678, 4'hF, 1'b1, 1'b0);
      put(32'h0002_000C, 32'h0000_00FF, 4'b0001, 1'b1, 1'b0);
      put(32'h0002_000C, 32'h0, 4'h0, 1'b0, 1'b1);
      chk("scratch", rd_data, 32'h1234_56FF);
      put(32'h0002_0000, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0);
      put(32'h0002_0004, 32'h0, 4'h0, 1'b0, 1'b1);
      chk("cyc_hi", rd_data, 32'd0);
      put(32'h0002_0000, 32'h0, 4'h0, 1'b0, 1'b1);
      ca = rd_data;
      repeat (4) put(32'h0002_0000, 32'h0, 4'h0, 1'b0, 1'b0);
      put(32'h0002_0000, 32'h0, 4'h0, 1'b0, 1'b1);
      cb = rd_data;
      chk("cyc_delta5", cb - ca, 32'd5);
      force dut.u_mmio.cyc_q = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut.u_mmio.cyc_q;
      #1;
      chk("cyc_max_lo", rd_data, 32'hFFFF_FFFF);
      put(32'h0002_0000, 32'h0, 4'h0, 1'b0, 1'b1);
      chk("cyc_wrap_lo", rd_data, 32'd0);
      put(32'h0002_0004, 32'h0, 4'h0, 1'b0, 1'b1);
      chk("cyc_wrap_hi", rd_data, 32'd0);
      chk("mmio_nofault", {31'b0, fault}, 32'd0);
`else
      put(32'h0002_000C, 32'h0, 4'h0, 1'b0, 1'b1);
      chk("nommio_rd0", rd_data, 32'd0);
      put(32'h0002_0008, 32'h1, 4'hF, 1'b1, 1'b0);
      chk("nommio_fault", {31'b0, fault}, 32'd1);
      chk("nommio_faddr", fault_addr, 32'h0002_000C);
      put(32'h0002_0000, 32'h0, 4'h0, 1'b0, 1'b0);
      chk("nommio_thv", {31'b0, tohost_valid}, 32'd0);
      chk("nommio_thd", tohost_data, 32'd0);
`endif

      @(negedge clk);
      rst = 1'b0;
      req.addr    = 32'h0001_0000;
      req.wr_data = 32'h0BAD_BEEF;
      req.byte_en = 4'hF;
      req.wr_en   = 1'b1;
      req.rd_en   = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      req.wr_en = 1'b0;
      req.rd_en = 1'b1;
      #1;
      chk("rstw_ram", rd_data, 32'hCAFE_F00D);
      chk("rstw_fault", {31'b0, fault}, 32'd0);
      chk("rstw_faddr", fault_addr, 32'd0);
      chk("rstw_thv", {31'b0, tohost_valid}, 32'd0);
      chk("rstw_thd", tohost_data, 32'd0);
`ifdef DMEM_MMIO_EN
      put(32'h0002_000C, 32'h0, 4'h0, 1'b0, 1'b1);
      chk("rstw_scratch", rd_data, 32'd0);
`endif

      put(32'h0001_0020, 32'h55AA_55AA, 4'hF, 1'b1, 1'b0);
      put(32'h0001_0020, 32'h0000_1234, 4'hF, 1'b1, 1'b1);
      chk("rw_rd0", rd_data, 32'd0);
      put(32'h0001_0020, 32'h0, 4'h0, 1'b0, 1'b1);
      chk("rw_nowrite", rd_data, 32'h55AA_55AA);
      chk("rw_fault", {31'b0, fault}, 32'd1);
      chk("rw_faddr", fault_addr, 32'h0001_0020);

      @(negedge clk);
      rst = 1'b0;
      req = '0;
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst2_fault", {31'b0, fault}, 32'd0);

      put(32'h0003_0000, 32'h0, 4'h0, 1'b0, 1'b1);
      chk("oor_rd0", rd_data, 32'd0);
      put(32'h0004_0000, 32'h0, 4'h0, 1'b0, 1'b1);
      chk("oor_fault", {31'b0, fault}, 32'd1);
      chk("oor_faddr", fault_addr, 32'h0003_0000);
      put(32'h0001_1000, 32'h0, 4'h0, 1'b0, 1'b1);
      chk("past_ram_rd0", rd_data, 32'd0);
      chk("oor_sticky", fault_addr, 32'h0003_0000);
      put(32'h0001_0000, 32'h0, 4'h0, 1'b0, 1'b0);
      chk("oor_sticky2", fault_addr, 32'h0003_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
